// File: rtl/zorro2_pkg.sv
// rtl/zorro2_pkg.sv - shared states, timing defaults and byte-enable codes
package zorro2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ASSERT,
    WAIT,
    SAMPLE,
    RELEASE,
    HOLD,
    RESP
  } state_t;

  localparam int DEF_ADDR_SETUP     = 2;
  localparam int DEF_DS_DELAY       = 2;
  localparam int DEF_DATA_HOLD      = 2;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  localparam logic [1:0] BE_NONE  = 2'b00;
  localparam logic [1:0] BE_LOWER = 2'b01;
  localparam logic [1:0] BE_UPPER = 2'b10;
  localparam logic [1:0] BE_WORD  = 2'b11;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer with selectable reset level
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/zorro2_bus_master.sv
// rtl/zorro2_bus_master.sv - Zorro II single-word bus initiator
// Define ZM_TIMEOUT_EN to add the WAIT-state watchdog and rsp_timeout.
module zorro2_bus_master
  import zorro2_pkg::*;
#(
  parameter int ADDR_SETUP     = DEF_ADDR_SETUP,
  parameter int DS_DELAY       = DEF_DS_DELAY,
  parameter int DATA_HOLD      = DEF_DATA_HOLD,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [22:0] req_addr,
  input  logic        req_rw,
  input  logic [1:0]  req_be,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_berr,
  output logic        rsp_timeout,
  output logic [22:0] A,
  output logic        RW,
  output logic        AS,
  output logic        UDS,
  output logic        LDS,
  input  logic [15:0] DA_I,
  output logic [15:0] DA_O,
  output logic        DA_OE,
  input  logic        DTACK,
  input  logic        BERR
);

  localparam int PHASE_MAX = max3(ADDR_SETUP, DS_DELAY, DATA_HOLD);
  localparam int CW        = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;

  // Out-of-range timing parameters leave this marker scope in the hierarchy.
  if (ADDR_SETUP < 1 || DS_DELAY < 1 || DATA_HOLD < 1 || TIMEOUT_CYCLES < 4) begin : g_param_range_violation
  end

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [1:0]      be_q, be_d;
  logic [22:0]     a_d;
  logic            rw_d, as_d, uds_d, lds_d, da_oe_d, req_ready_d;
  logic [15:0]     da_o_d, rsp_rdata_d;
  logic            rsp_valid_d, rsp_berr_d;
  logic            dtack_s, berr_s;

`ifdef ZM_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd, wd_d;
  logic            rsp_timeout_d;
`endif

  sync2 #(.RESET_VAL(1'b1)) u_sync_dtack (.clk(mclk), .reset(reset), .d(DTACK), .q(dtack_s));
  sync2 #(.RESET_VAL(1'b1)) u_sync_berr  (.clk(mclk), .reset(reset), .d(BERR),  .q(berr_s));

  always_ff @(posedge mclk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      be_q      <= BE_NONE;
      A         <= '0;
      RW        <= 1'b1;
      AS        <= 1'b1;
      UDS       <= 1'b1;
      LDS       <= 1'b1;
      DA_O      <= '0;
      DA_OE     <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_berr  <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      be_q      <= be_d;
      A         <= a_d;
      RW        <= rw_d;
      AS        <= as_d;
      UDS       <= uds_d;
      LDS       <= lds_d;
      DA_O      <= da_o_d;
      DA_OE     <= da_oe_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_berr  <= rsp_berr_d;
    end
  end

`ifdef ZM_TIMEOUT_EN
  always_ff @(posedge mclk) begin
    if (reset) begin
      wd          <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      wd          <= wd_d;
      rsp_timeout <= rsp_timeout_d;
    end
  end
`else
  assign rsp_timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    be_d        = be_q;
    a_d         = A;
    rw_d        = RW;
    as_d        = AS;
    uds_d       = UDS;
    lds_d       = LDS;
    da_o_d      = DA_O;
    da_oe_d     = DA_OE;
    req_ready_d = req_ready;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    rsp_berr_d  = rsp_berr;
`ifdef ZM_TIMEOUT_EN
    wd_d          = wd;
    rsp_timeout_d = rsp_timeout;
`endif

    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          req_ready_d = 1'b0;
          be_d        = req_be;
          cnt_d       = '0;
          rsp_berr_d  = 1'b0;
`ifdef ZM_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
          // A request with no byte lanes never touches the bus.
          if (req_be == BE_NONE) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_berr_d  = 1'b1;
          end else begin
            state_d = ADDR;
            a_d     = req_addr;
            rw_d    = req_rw;
            if (!req_rw) begin
              da_o_d  = req_wdata;
              da_oe_d = 1'b1;
            end
          end
        end
      end

      ADDR: begin
        if (cnt == CW'(ADDR_SETUP - 1)) begin
          state_d = ASSERT;
          cnt_d   = '0;
          as_d    = 1'b0;
          if (RW) begin
            uds_d = ~be_q[1];
            lds_d = ~be_q[0];
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      ASSERT: begin
        // Reads already have their strobes; writes wait DS_DELAY for data to settle.
        if (RW || cnt == CW'(DS_DELAY - 1)) begin
          state_d = WAIT;
          cnt_d   = '0;
          uds_d   = ~be_q[1];
          lds_d   = ~be_q[0];
`ifdef ZM_TIMEOUT_EN
          wd_d    = '0;
`endif
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      WAIT: begin
        if (!berr_s) begin
          state_d    = RELEASE;
          rsp_berr_d = 1'b1;
          as_d       = 1'b1;
          uds_d      = 1'b1;
          lds_d      = 1'b1;
        end else if (!dtack_s) begin
          state_d = SAMPLE;
        end
`ifdef ZM_TIMEOUT_EN
        else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
          state_d       = RELEASE;
          rsp_timeout_d = 1'b1;
          as_d          = 1'b1;
          uds_d         = 1'b1;
          lds_d         = 1'b1;
        end else begin
          wd_d = wd + 1'b1;
        end
`endif
      end

      SAMPLE: begin
        if (RW) begin
          rsp_rdata_d = DA_I;
        end
        state_d = RELEASE;
        as_d    = 1'b1;
        uds_d   = 1'b1;
        lds_d   = 1'b1;
      end

      RELEASE: begin
        if (cnt == CW'(DATA_HOLD - 1)) begin
          state_d = HOLD;
          cnt_d   = '0;
          da_oe_d = 1'b0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      HOLD: begin
        // The responder must have withdrawn both terminations before we finish.
        if (dtack_s && berr_s) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rw_d        = 1'b1;
        end
      end

      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
